// File: rtl/phase_monitor_if.sv
// ---------------------------------------------------------------------------
// phase_monitor_if
// Bundles the three-phase strobe bus seen by phase_monitor together with its
// status outputs.
//   master : strobe driver side (phase generator / halt controller / debug)
//            drives cycle_clock, ram_clock, internal_clock, halt, clear_fault
//            and observes phase, cycle_count, running, fault, fault_code.
//   slave  : phase_monitor side, the mirror image of master.
// Parameter CNT_W must match the CNT_W of the attached phase_monitor.
// ---------------------------------------------------------------------------
interface phase_monitor_if #(
    parameter int CNT_W = 32
);
    logic             cycle_clock;
    logic             ram_clock;
    logic             internal_clock;
    logic             halt;
    logic             clear_fault;
    logic [1:0]       phase;
    logic [CNT_W-1:0] cycle_count;
    logic             running;
    logic             fault;
    logic [2:0]       fault_code;

    modport master (
        output cycle_clock, ram_clock, internal_clock, halt, clear_fault,
        input  phase, cycle_count, running, fault, fault_code
    );

    modport slave (
        input  cycle_clock, ram_clock, internal_clock, halt, clear_fault,
        output phase, cycle_count, running, fault, fault_code
    );
endinterface

// File: rtl/phase_monitor.sv
// ---------------------------------------------------------------------------
// phase_monitor
// Receive end of the three-phase strobe interface. Locks onto the one-hot
// rotation cycle -> ram -> internal, tolerates halt gaps, counts completed
// machine cycles and latches a sticky fault code on protocol violations.
//
// Ports
//   clk      : system clock, everything on posedge
//   reset_n  : synchronous reset, active-low
//   bus      : phase_monitor_if.slave
//              in  cycle_clock, ram_clock, internal_clock, halt, clear_fault
//              out phase, cycle_count, running, fault, fault_code
//
// Parameters
//   CNT_W        width of cycle_count (wraps modulo 2**CNT_W)
//   STALL_LIMIT  clk cycles with no strobe and no halt before a stall fault
//
// Build option
//   PHASE_MON_STALL_DET_EN : when defined, a stall timer is built and may
//   raise fault code 4. When undefined no timer exists and code 4 never
//   appears.
//
// State table
//   state   | meaning
//   SYNC    | waiting for a cycle strobe to lock onto the rotation
//   EXP_RAM | locked, next strobe must be ram_clock
//   EXP_INT | locked, next strobe must be internal_clock
//   EXP_CYC | locked, next strobe must be cycle_clock
//   FAULT   | violation seen, outputs frozen until clear_fault
// ---------------------------------------------------------------------------
module phase_monitor #(
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    phase_monitor_if.slave bus
);

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        EXP_RAM = 3'd1,
        EXP_INT = 3'd2,
        EXP_CYC = 3'd3,
        FAULT   = 3'd4
    } state_t;

    localparam logic [2:0] V_CYC = 3'b100;
    localparam logic [2:0] V_RAM = 3'b010;
    localparam logic [2:0] V_INT = 3'b001;

    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_MULTI = 3'd1;
    localparam logic [2:0] CODE_ORDER = 3'd2;
    localparam logic [2:0] CODE_GAP   = 3'd3;
`ifdef PHASE_MON_STALL_DET_EN
    localparam logic [2:0] CODE_STALL = 3'd4;
`endif

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       code_q, code_d;
    logic             running_q;
    logic             fault_q;
    logic             halt_q;

    logic [2:0]       v;
    logic             multi_hot;
    logic             locked;
    logic [2:0]       v_expected;
    logic             stall_hit;

    assign v         = {bus.cycle_clock, bus.ram_clock, bus.internal_clock};
    assign multi_hot = (v & (v - 3'd1)) != 3'd0;
    assign locked    = (state_q == EXP_RAM) || (state_q == EXP_INT) || (state_q == EXP_CYC);

`ifdef PHASE_MON_STALL_DET_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    // Down-counter: reloads with the limit whenever the bus is alive or
    // legally halted; terminal count zero means STALL_LIMIT idle clocks.
    logic [STALL_W-1:0] stall_left;

    always_ff @(posedge clk) begin
        if (!reset_n || !locked || (v != 3'd0) || halt_q) begin
            stall_left <= STALL_W'(STALL_LIMIT);
        end else if (stall_left != '0) begin
            stall_left <= stall_left - STALL_W'(1);
        end
    end

    assign stall_hit = (stall_left == '0);
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        unique case (state_q)
            EXP_RAM: v_expected = V_RAM;
            EXP_INT: v_expected = V_INT;
            EXP_CYC: v_expected = V_CYC;
            default: v_expected = 3'b000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        code_d  = code_q;

        if (state_q == FAULT) begin
            // Strobes in the clearing clock are deliberately not evaluated.
            if (bus.clear_fault) begin
                state_d = SYNC;
                code_d  = CODE_NONE;
            end
        end else if (multi_hot) begin
            state_d = FAULT;
            code_d  = CODE_MULTI;
        end else if (state_q == SYNC) begin
            if (v == V_CYC) begin
                state_d = EXP_RAM;
                phase_d = 2'd1;
            end
        end else if (v == v_expected) begin
            unique case (state_q)
                EXP_RAM: begin
                    state_d = EXP_INT;
                    phase_d = 2'd2;
                end
                EXP_INT: begin
                    state_d = EXP_CYC;
                    phase_d = 2'd3;
                    count_d = count_q + CNT_W'(1);
                end
                default: begin
                    state_d = EXP_RAM;
                    phase_d = 2'd1;
                end
            endcase
        end else if (v == 3'b000) begin
            // A gap only counts as legal when halt was seen one clock earlier,
            // matching the generator's one-clock reaction to halt.
            if (halt_q) begin
                phase_d = 2'd0;
            end else begin
                state_d = FAULT;
                code_d  = CODE_GAP;
            end
        end else begin
            state_d = FAULT;
            code_d  = CODE_ORDER;
        end

`ifdef PHASE_MON_STALL_DET_EN
        if (locked && (state_d != FAULT) && stall_hit) begin
            state_d = FAULT;
            code_d  = CODE_STALL;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= SYNC;
            phase_q   <= 2'd0;
            count_q   <= '0;
            code_q    <= CODE_NONE;
            running_q <= 1'b0;
            fault_q   <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            count_q   <= count_d;
            code_q    <= code_d;
            running_q <= (state_d == EXP_RAM) || (state_d == EXP_INT) || (state_d == EXP_CYC);
            fault_q   <= (state_d == FAULT);
            halt_q    <= bus.halt;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.cycle_count = count_q;
    assign bus.running     = running_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;

endmodule

// File: tb/tb_phase_monitor.sv
// ---------------------------------------------------------------------------
// tb_phase_monitor
// Self-checking bench for phase_monitor (CNT_W=4, STALL_LIMIT=16). Each
// stimulus clock pushes the hand-derived expected outputs; a monitor pops
// and compares them just after the following rising edge. Expectations are
// identical with or without PHASE_MON_STALL_DET_EN.
// ---------------------------------------------------------------------------
module tb_phase_monitor;

    localparam int CW = 4;

    logic clk;
    logic reset_n;

    phase_monitor_if #(.CNT_W(CW)) bus ();

    phase_monitor #(
        .CNT_W       (CW),
        .STALL_LIMIT (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    ph;     // -1 means phase not checked
        int    cnt;
        bit    run;
        bit    flt;
        int    code;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.ph >= 0) chk({e.tag, ".phase"}, 32'(bus.phase), e.ph);
            chk({e.tag, ".count"},   32'(bus.cycle_count), e.cnt);
            chk({e.tag, ".running"}, 32'(bus.running),     32'(e.run));
            chk({e.tag, ".fault"},   32'(bus.fault),       32'(e.flt));
            chk({e.tag, ".code"},    32'(bus.fault_code),  e.code);
        end
    end

    task automatic step(input string tag, input logic [2:0] v, input logic h,
                        input logic clr, input logic rn, input int ph, input int cnt,
                        input bit run, input bit flt, input int code);
        exp_t e;
        {bus.cycle_clock, bus.ram_clock, bus.internal_clock} = v;
        bus.halt        = h;
        bus.clear_fault = clr;
        reset_n         = rn;
        e.tag  = tag;
        e.ph   = ph;
        e.cnt  = cnt;
        e.run  = run;
        e.flt  = flt;
        e.code = code;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {bus.cycle_clock, bus.ram_clock, bus.internal_clock} = 3'b000;
        bus.halt        = 1'b0;
        bus.clear_fault = 1'b0;
        reset_n         = 1'b0;
        @(negedge clk);

        // reset
        step("rst0", 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst1", 3'b000, 0, 0, 1, 0, 0, 0, 0, 0);

        // three clean triplets
        for (int k = 0; k < 3; k++) begin
            step("t1_cyc", 3'b100, 0, 0, 1, 1, k,     1, 0, 0);
            step("t1_ram", 3'b010, 0, 0, 1, 2, k,     1, 0, 0);
            step("t1_int", 3'b001, 0, 0, 1, 3, k + 1, 1, 0, 0);
        end

        // legal halt gap while expecting the internal strobe
        step("t2_cyc",  3'b100, 0, 0, 1, 1, 3, 1, 0, 0);
        step("t2_ram",  3'b010, 1, 0, 1, 2, 3, 1, 0, 0);
        step("t2_gap1", 3'b000, 1, 0, 1, 0, 3, 1, 0, 0);
        step("t2_gap2", 3'b000, 1, 0, 1, 0, 3, 1, 0, 0);
        step("t2_gap3", 3'b000, 1, 0, 1, 0, 3, 1, 0, 0);
        step("t2_gap4", 3'b000, 0, 0, 1, 0, 3, 1, 0, 0);
        step("t2_int",  3'b001, 0, 0, 1, 3, 4, 1, 0, 0);

        // out-of-order strobe, then recovery via clear_fault
        step("t3_cyc",   3'b100, 0, 0, 1, 1,  4, 1, 0, 0);
        step("t3_bad",   3'b001, 0, 0, 1, 1,  4, 0, 1, 2);
        step("t3_hold",  3'b000, 0, 0, 1, 1,  4, 0, 1, 2);
        step("t3_clr",   3'b100, 0, 1, 1, -1, 4, 0, 0, 0);
        step("t3_relck", 3'b100, 0, 0, 1, 1,  4, 1, 0, 0);

        // unexpected gap, sticky code, multi-hot in SYNC
        step("t4_ram",   3'b010, 0, 0, 1, 2,  4, 1, 0, 0);
        step("t4_int",   3'b001, 0, 0, 1, 3,  5, 1, 0, 0);
        step("t4_gap",   3'b000, 0, 0, 1, 3,  5, 0, 1, 3);
        step("t4_stick", 3'b011, 0, 0, 1, 3,  5, 0, 1, 3);
        step("t4_clr1",  3'b000, 0, 1, 1, -1, 5, 0, 0, 0);
        step("t4_sync",  3'b010, 0, 0, 1, -1, 5, 0, 0, 0);
        step("t4_multi", 3'b110, 0, 0, 1, -1, 5, 0, 1, 1);
        step("t4_keep",  3'b001, 0, 0, 1, -1, 5, 0, 1, 1);
        step("t4_clr2",  3'b000, 0, 1, 1, -1, 5, 0, 0, 0);
        step("t4_wait1", 3'b001, 0, 0, 1, -1, 5, 0, 0, 0);
        step("t4_wait2", 3'b000, 0, 0, 1, -1, 5, 0, 0, 0);

        // 16 triplets: count wraps 15 -> 0 and returns to 5
        for (int k = 0; k < 16; k++) begin
            step("t5_cyc", 3'b100, 0, 0, 1, 1, (5 + k) % 16,     1, 0, 0);
            step("t5_ram", 3'b010, 0, 0, 1, 2, (5 + k) % 16,     1, 0, 0);
            step("t5_int", 3'b001, 0, 0, 1, 3, (5 + k + 1) % 16, 1, 0, 0);
        end

        // reset mid-triplet
        step("t5_pre",  3'b100, 0, 0, 1, 1, 5, 1, 0, 0);
        step("t5_rst",  3'b010, 0, 0, 0, 0, 0, 0, 0, 0);
        step("t5_rel",  3'b000, 0, 0, 1, 0, 0, 0, 0, 0);

        // long halt gap, then gap without halt
        step("t6_cyc",  3'b100, 0, 0, 1, 1, 0, 1, 0, 0);
        step("t6_ram",  3'b010, 0, 0, 1, 2, 0, 1, 0, 0);
        step("t6_int",  3'b001, 0, 0, 1, 3, 1, 1, 0, 0);
        step("t6_cyc2", 3'b100, 1, 0, 1, 1, 1, 1, 0, 0);
        for (int k = 0; k < 20; k++) begin
            step("t6_halt", 3'b000, 1, 0, 1, 0, 1, 1, 0, 0);
        end
        step("t6_tail", 3'b000, 0, 0, 1, 0, 1, 1, 0, 0);
        step("t6_gap",  3'b000, 0, 0, 1, 0, 1, 0, 1, 3);
        step("t6_clr",  3'b100, 0, 1, 1, -1, 1, 0, 0, 0);
        step("t6_lock", 3'b100, 0, 0, 1, 1, 1, 1, 0, 0);

        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
